// File: rtl/wb_shadow_pkg.sv
// Shared types and helpers for the Wishbone shadow-memory slave model.
package wb_shadow_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        ACK  = 2'd2
    } state_t;

    // Wait-state counter covers WAIT_STATES up to 15
    localparam int unsigned CNT_W = $clog2(16);

    function automatic int unsigned sel_width(input int unsigned data_width);
        return data_width / 8;
    endfunction

endpackage

// File: rtl/wb_shadow_word.sv
// One tracked word: address compare plus byte-lane shadow data and valid flags.
module wb_shadow_word
    import wb_shadow_pkg::*;
#(
    parameter  int unsigned ADDR_WIDTH  = 30,
    parameter  int unsigned DATA_WIDTH  = 32,
    parameter  int unsigned UNINIT_FREE = 1,
    localparam int unsigned SEL_WIDTH   = sel_width(DATA_WIDTH)
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [ADDR_WIDTH-1:0] entry_adr,
    input  logic [ADDR_WIDTH-1:0] bus_adr,
    input  logic                  commit,
    input  logic [SEL_WIDTH-1:0]  sel,
    input  logic [DATA_WIDTH-1:0] dat_w,
    output logic                  match,
    output logic [DATA_WIDTH-1:0] data,
    output logic [SEL_WIDTH-1:0]  valid
);

    assign match = (entry_adr == bus_adr);

    // Only selected lanes are written and become valid
    always_ff @(posedge clock) begin
        if (reset) begin
            data  <= '0;
            valid <= {SEL_WIDTH{UNINIT_FREE == 0}};
        end else if (commit && match) begin
            for (int i = 0; i < int'(SEL_WIDTH); i++) begin
                if (sel[i]) begin
                    data[i*8 +: 8] <= dat_w[i*8 +: 8];
                end
            end
            valid <= valid | sel;
        end
    end

endmodule

// File: rtl/wb_shadow_mem.sv
// Wishbone-classic slave model with per-word byte shadows, wait states and a sticky protocol flag.
module wb_shadow_mem
    import wb_shadow_pkg::*;
#(
    parameter  int unsigned ADDR_WIDTH  = 30,
    parameter  int unsigned DATA_WIDTH  = 32,
    parameter  int unsigned NUM_WORDS   = 4,
    parameter  int unsigned WAIT_STATES = 0,
    parameter  int unsigned UNINIT_FREE = 1,
    localparam int unsigned SEL_WIDTH   = sel_width(DATA_WIDTH),
    localparam int unsigned IDX_W       = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1
) (
    input  logic                            clock,
    input  logic                            reset,
    input  logic [NUM_WORDS*ADDR_WIDTH-1:0] track_adr,
    input  logic [ADDR_WIDTH-1:0]           wb_adr,
    input  logic [DATA_WIDTH-1:0]           wb_dat_w,
    input  logic [SEL_WIDTH-1:0]            wb_sel,
    input  logic                            wb_cyc,
    input  logic                            wb_stb,
    input  logic                            wb_we,
    input  logic [DATA_WIDTH-1:0]           rand_dat,
    output logic [DATA_WIDTH-1:0]           wb_dat_r,
    output logic                            wb_ack,
    output logic                            hit,
    output logic [IDX_W-1:0]                hit_idx,
    output logic [NUM_WORDS*SEL_WIDTH-1:0]  shadow_valid,
    output logic                            proto_err
);

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'((WAIT_STATES > 0) ? WAIT_STATES - 1 : 0);

    state_t                          state;
    logic [CNT_W-1:0]                cnt;
    logic [ADDR_WIDTH-1:0]           lat_adr;
    logic                            lat_we;
    logic [SEL_WIDTH-1:0]            lat_sel;
    logic [DATA_WIDTH-1:0]           lat_dat;
    logic [NUM_WORDS*ADDR_WIDTH-1:0] track_q;

    logic                  req;
    logic                  req_changed;
    logic                  commit;
    logic [NUM_WORDS-1:0]  match;
    logic [DATA_WIDTH-1:0] word_dat [NUM_WORDS];
    logic [SEL_WIDTH-1:0]  word_val [NUM_WORDS];

    assign req         = wb_cyc & wb_stb;
    assign req_changed = (wb_adr != lat_adr) | (wb_we != lat_we) | (wb_sel != lat_sel)
                       | (lat_we & (wb_dat_w != lat_dat));
    assign wb_ack      = (state == ACK) & req & ~reset;
    assign commit      = wb_ack & wb_we;

    // Transfer FSM; the tracked address table is frozen once reset falls
    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= IDLE;
            cnt       <= '0;
            proto_err <= 1'b0;
            track_q   <= track_adr;
            lat_adr   <= '0;
            lat_we    <= 1'b0;
            lat_sel   <= '0;
            lat_dat   <= '0;
        end else begin
            if ((state != IDLE) && req && req_changed) begin
                proto_err <= 1'b1;
            end
            case (state)
                IDLE: begin
                    if (req) begin
                        lat_adr <= wb_adr;
                        lat_we  <= wb_we;
                        lat_sel <= wb_sel;
                        lat_dat <= wb_dat_w;
                        cnt     <= '0;
                        if (WAIT_STATES != 0) begin
                            state <= WAIT;
                        end else begin
                            state <= ACK;
                        end
                    end
                end
                WAIT: begin
                    if (!req) begin
                        state <= IDLE;
                    end else if (cnt == LAST_CNT) begin
                        state <= ACK;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                ACK:     state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    for (genvar k = 0; k < int'(NUM_WORDS); k++) begin : g_word
        wb_shadow_word #(
            .ADDR_WIDTH  (ADDR_WIDTH),
            .DATA_WIDTH  (DATA_WIDTH),
            .UNINIT_FREE (UNINIT_FREE)
        ) u_word (
            .clock     (clock),
            .reset     (reset),
            .entry_adr (track_q[k*ADDR_WIDTH +: ADDR_WIDTH]),
            .bus_adr   (wb_adr),
            .commit    (commit),
            .sel       (wb_sel),
            .dat_w     (wb_dat_w),
            .match     (match[k]),
            .data      (word_dat[k]),
            .valid     (word_val[k])
        );
        assign shadow_valid[k*SEL_WIDTH +: SEL_WIDTH] = word_val[k];
    end

    assign hit = |match;

    // Lowest matching entry wins
    always_comb begin
        hit_idx = '0;
        for (int k = int'(NUM_WORDS) - 1; k >= 0; k--) begin
            if (match[k]) begin
                hit_idx = IDX_W'(k);
            end
        end
    end

    always_comb begin
        wb_dat_r = rand_dat;
        if (hit) begin
            for (int i = 0; i < int'(SEL_WIDTH); i++) begin
                if (word_val[hit_idx][i]) begin
                    wb_dat_r[i*8 +: 8] = word_dat[hit_idx][i*8 +: 8];
                end
            end
        end
    end

endmodule
